// File: rtl/flt2int_core.sv
// Iterative 16-bit float to 16-bit sign-magnitude integer converter.
// One shift bit per clock, round-to-nearest-even, saturating on overflow.
module flt2int_core #(
    parameter int unsigned BIAS    = 15,
    parameter logic [14:0] SAT_MAG = 15'h7FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] flt_in,
    output logic [15:0] int_out,
    output logic        done,
    output logic        busy,
    output logic        ovf
);

    localparam logic [4:0] INT_EXP = 5'(BIAS + 10);
    localparam logic [4:0] MAX_EXP = 5'(BIAS + 14);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_ROUND,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [4:0]  exp_q, exp_d;
    logic [14:0] sig_q, sig_d;
    logic        guard_q, guard_d;
    logic        sticky_q, sticky_d;
    logic        left_q, left_d;
    logic        sat_q, sat_d;
    logic        zero_q, zero_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] int_out_q, int_out_d;
    logic        ovf_q, ovf_d;

    logic [4:0]  dn_n;
    logic        rnd_up;
    logic [14:0] mag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            sig_q     <= '0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            left_q    <= 1'b0;
            sat_q     <= 1'b0;
            zero_q    <= 1'b0;
            cnt_q     <= '0;
            int_out_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            sig_q     <= sig_d;
            guard_q   <= guard_d;
            sticky_q  <= sticky_d;
            left_q    <= left_d;
            sat_q     <= sat_d;
            zero_q    <= zero_d;
            cnt_q     <= cnt_d;
            int_out_q <= int_out_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        sig_d     = sig_q;
        guard_d   = guard_q;
        sticky_d  = sticky_q;
        left_d    = left_q;
        sat_d     = sat_q;
        zero_d    = zero_q;
        cnt_d     = cnt_q;
        int_out_d = int_out_q;
        ovf_d     = ovf_q;
        dn_n      = INT_EXP - exp_q;
        rnd_up    = 1'b0;
        mag       = sig_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    sign_d   = flt_in[15];
                    exp_d    = flt_in[14:10];
                    sig_d    = {4'b0000, 1'b1, flt_in[9:0]};
                    guard_d  = 1'b0;
                    sticky_d = 1'b0;
                    ovf_d    = 1'b0;
                    sat_d    = 1'b0;
                    zero_d   = 1'b0;
                    left_d   = 1'b0;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_ROUND;
                if (exp_q == 5'd0) begin
                    zero_d = 1'b1;
                end else if (exp_q > MAX_EXP) begin
                    sat_d = 1'b1;
                end else if (exp_q > INT_EXP) begin
                    left_d  = 1'b1;
                    cnt_d   = 4'(exp_q - INT_EXP);
                    state_d = S_SHIFT;
                end else if (exp_q < INT_EXP) begin
                    // Beyond 12 right shifts every significand bit is already in sticky.
                    left_d  = 1'b0;
                    cnt_d   = (dn_n > 5'd12) ? 4'd12 : 4'(dn_n);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (left_q) begin
                    sig_d = {sig_q[13:0], 1'b0};
                end else begin
                    sticky_d = sticky_q | guard_q;
                    guard_d  = sig_q[0];
                    sig_d    = {1'b0, sig_q[14:1]};
                end
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                rnd_up = guard_q & (sticky_q | sig_q[0]);
                mag    = sig_q + {14'b0, rnd_up};
                if (sat_q) begin
                    mag   = SAT_MAG;
                    ovf_d = 1'b1;
                end else if (zero_q) begin
                    mag = '0;
                end
                int_out_d = {sign_q, mag};
                state_d   = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign int_out = int_out_q;
    assign ovf     = ovf_q;
    assign done    = (state_q == S_DONE);
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_flt2int_core.sv
// Directed-vector bench for flt2int_core: results, latency, handshake and async reset.
module tb_flt2int_core;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] flt_in;
    logic [15:0] int_out;
    logic        done;
    logic        busy;
    logic        ovf;

    int unsigned n_chk;
    int unsigned n_bad;

    flt2int_core #(
        .BIAS   (15),
        .SAT_MAG(15'h7FFF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flt_in (flt_in),
        .int_out(int_out),
        .done   (done),
        .busy   (busy),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (busy) chk("idle_timeout", 16'(busy), 16'd0);
    endtask

    // Cycle count includes the accepting edge, so n shifts give n+3.
    task automatic convert(input string tag, input logic [15:0] f, input logic [15:0] exp_out,
                           input logic exp_ovf, input int exp_cyc);
        int  k;
        logic busy_ok;
        wait_idle();
        @(negedge clk);
        start  = 1'b1;
        flt_in = f;
        @(posedge clk);
        #1;
        start   = 1'b0;
        flt_in  = 16'hA5A5;
        k       = 1;
        busy_ok = busy;
        while (!done && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            flt_in = 16'($urandom);
            if (!busy) busy_ok = 1'b0;
        end
        chk({tag, "_cyc"}, 16'(k), 16'(exp_cyc));
        chk({tag, "_busy"}, 16'(busy_ok), 16'd1);
        chk({tag, "_out"}, int_out, exp_out);
        chk({tag, "_ovf"}, 16'(ovf), 16'(exp_ovf));
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 16'({done, busy}), 16'd0);
    endtask

    task automatic handshake_test();
        int k;
        int dones;
        int first_k;
        wait_idle();
        @(negedge clk);
        start  = 1'b1;
        flt_in = 16'h3C00;
        @(posedge clk);
        #1;
        start   = 1'b0;
        k       = 1;
        dones   = 0;
        first_k = 0;
        while (k < 22) begin
            if (k == 2 || k == 8) begin
                start  = 1'b1;
                flt_in = 16'h7C00;
            end else begin
                start  = 1'b0;
                flt_in = 16'($urandom);
            end
            @(posedge clk);
            #1;
            k++;
            if (done) begin
                dones++;
                if (first_k == 0) first_k = k;
            end
        end
        start = 1'b0;
        chk("hs_dones", 16'(dones), 16'd1);
        chk("hs_cyc", 16'(first_k), 16'd13);
        chk("hs_out_hold", int_out, 16'h0001);
        chk("hs_ovf", 16'(ovf), 16'd0);
        chk("hs_idle", 16'(busy), 16'd0);
    endtask

    task automatic reset_test();
        int k;
        int dones;
        wait_idle();
        @(negedge clk);
        start  = 1'b1;
        flt_in = 16'hC100;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        #3;
        reset = 1'b1;
        #1;
        chk("rst_mid_out", int_out, 16'h0000);
        chk("rst_mid_flags", 16'({done, busy, ovf}), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        chk("rst_no_done", 16'(dones), 16'd0);
        convert("post_rst", 16'h3C00, 16'h0001, 1'b0, 13);
    endtask

    initial begin
        n_chk  = 0;
        n_bad  = 0;
        reset  = 1'b1;
        start  = 1'b0;
        flt_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", int_out, 16'h0000);
        chk("reset_flags", 16'({done, busy, ovf}), 16'd0);
        @(negedge clk);
        reset = 1'b0;

        convert("sat30",   16'h7800, 16'h7FFF, 1'b1, 3);
        convert("one",     16'h3C00, 16'h0001, 1'b0, 13);
        convert("half",    16'h3800, 16'h0000, 1'b0, 14);
        convert("one5",    16'h3E00, 16'h0002, 1'b0, 13);
        convert("two5",    16'h4100, 16'h0002, 1'b0, 12);
        convert("mtwo5",   16'hC100, 16'h8002, 1'b0, 12);
        convert("p75",     16'h3A01, 16'h0001, 1'b0, 14);
        convert("lsh4",    16'h7400, 16'h4000, 1'b0, 7);
        convert("exp25",   16'h67FF, 16'h07FF, 1'b0, 3);
        convert("carry",   16'h63FF, 16'h0400, 1'b0, 4);
        convert("zero",    16'h0000, 16'h0000, 1'b0, 3);
        convert("negzero", 16'h8000, 16'h8000, 1'b0, 3);
        convert("exp13",   16'h37FF, 16'h0000, 1'b0, 15);
        convert("neg_sml", 16'hB600, 16'h8000, 1'b0, 15);
        convert("exp1",    16'h0401, 16'h0000, 1'b0, 15);
        convert("inf",     16'h7C00, 16'h7FFF, 1'b1, 3);

        handshake_test();
        reset_test();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
